// File: rtl/riscv_pkg.sv
// Shared types for the data-memory path: arbiter state encoding and the
// one-hot store-width codes produced by the decoder.
package riscv_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACC_C  = 3'd1,
    ACC_U  = 3'd2,
    RESP_C = 3'd3,
    RESP_U = 3'd4
  } dmem_state_e;

  // storecntrl is one-hot {sw, sh, sb}
  localparam logic [2:0] SW = 3'b100;
  localparam logic [2:0] SH = 3'b010;
  localparam logic [2:0] SB = 3'b001;

endpackage

// File: rtl/store_lane_gen.sv
// Byte-lane steering for core stores: byte enables, lane-replicated write
// data and misalignment detection from the low address bits.
module store_lane_gen
  import riscv_pkg::*;
(
  input  logic        is_store,
  input  logic [1:0]  offset,
  input  logic [2:0]  storecntrl,
  input  logic [31:0] wdata,
  output logic [3:0]  byte_we,
  output logic [31:0] lane_wdata,
  output logic        misalign
);

  always_comb begin
    byte_we    = 4'b0000;
    lane_wdata = wdata;
    misalign   = 1'b0;
    if (is_store) begin
      unique case (storecntrl)
        SW: begin
          byte_we  = 4'b1111;
          misalign = (offset != 2'b00);
        end
        SH: begin
          byte_we    = 4'b0011 << offset;
          lane_wdata = {2{wdata[15:0]}};
          misalign   = offset[0];
        end
        SB: begin
          byte_we    = 4'b0001 << offset;
          lane_wdata = {4{wdata[7:0]}};
        end
        default: byte_we = 4'b0000;
      endcase
      // A misaligned store still walks the full sequence but writes nothing.
      if (misalign) byte_we = 4'b0000;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (core MEM stage, UART loader) in front of a single
// synchronous data memory, alternating priority on contention.
module dmem_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter bit CORE_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_rd,
  input  logic              core_wr,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  input  logic [2:0]        core_storecntrl,
  input  logic              core_flush,
  output logic              core_stall,
  output logic [31:0]       core_rdata,
  output logic              core_misalign,
  input  logic              uart_req,
  input  logic              uart_we,
  input  logic [ADDR_W-1:0] uart_addr,
  input  logic [31:0]       uart_wdata,
  output logic              uart_ack,
  output logic [31:0]       uart_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output dmem_state_e       state_dbg
);

  // Handshakes: the core holds core_rd/core_wr and its operands stable until
  // a cycle with core_stall low, which is the completing cycle; the UART holds
  // uart_req until uart_ack. Operands are captured at grant, so a flush or a
  // dropped uart_req after grant cannot disturb an access already issued.

  dmem_state_e       state, state_nxt;
  logic              last_uart;
  logic              core_req, grant_core, grant_uart;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_wdata;
  logic [2:0]        c_cntrl;
  logic              c_store;
  logic [ADDR_W-3:0] u_word;
  logic [31:0]       u_wdata;
  logic              u_we;
  logic [3:0]        lane_we;
  logic [31:0]       lane_wdata;
  logic              lane_misalign;

  assign core_req  = (core_rd | core_wr) & ~core_flush;
  assign state_dbg = state;

  always_comb begin
    state_nxt  = state;
    grant_core = 1'b0;
    grant_uart = 1'b0;
    unique case (state)
      IDLE: begin
        if (core_req && (!uart_req || last_uart)) grant_core = 1'b1;
        else if (uart_req)                        grant_uart = 1'b1;
        if (grant_core)      state_nxt = ACC_C;
        else if (grant_uart) state_nxt = ACC_U;
      end
      ACC_C:          state_nxt = RESP_C;
      ACC_U:          state_nxt = RESP_U;
      RESP_C, RESP_U: state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_uart <= CORE_FIRST;
      c_addr    <= '0;
      c_wdata   <= '0;
      c_cntrl   <= '0;
      c_store   <= 1'b0;
      u_word    <= '0;
      u_wdata   <= '0;
      u_we      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_core) begin
        c_addr  <= core_addr;
        c_wdata <= core_wdata;
        c_cntrl <= core_storecntrl;
        c_store <= core_wr & ~core_rd;   // rd+wr together behaves as a load
      end
      if (grant_uart) begin
        u_word  <= uart_addr[ADDR_W-1:2];
        u_wdata <= uart_wdata;
        u_we    <= uart_we;
      end
      if (state == RESP_C) last_uart <= 1'b0;
      if (state == RESP_U) last_uart <= 1'b1;
    end
  end

  store_lane_gen u_lane (
    .is_store   (c_store),
    .offset     (c_addr[1:0]),
    .storecntrl (c_cntrl),
    .wdata      (c_wdata),
    .byte_we    (lane_we),
    .lane_wdata (lane_wdata),
    .misalign   (lane_misalign)
  );

  // The stall must react in the same cycle a request appears, so it looks at
  // the raw request lines rather than waiting for a grant.
  assign core_stall = (core_rd | core_wr) && (state != RESP_C);

  always_comb begin
    mem_en        = 1'b0;
    mem_we        = 4'b0000;
    mem_addr      = '0;
    mem_wdata     = '0;
    core_misalign = 1'b0;
    core_rdata    = '0;
    uart_ack      = 1'b0;
    uart_rdata    = '0;
    unique case (state)
      ACC_C: begin
        mem_en        = 1'b1;
        mem_we        = lane_we;
        mem_addr      = {c_addr[ADDR_W-1:2], 2'b00};
        mem_wdata     = lane_wdata;
        core_misalign = lane_misalign;
      end
      ACC_U: begin
        mem_en    = 1'b1;
        mem_we    = u_we ? 4'b1111 : 4'b0000;
        mem_addr  = {u_word, 2'b00};
        mem_wdata = u_wdata;
      end
      RESP_C: core_rdata = mem_rdata;
      RESP_U: begin
        uart_ack   = 1'b1;
        uart_rdata = mem_rdata;
      end
      default: ;
    endcase
  end

endmodule
